// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, constants and helpers for register_file_mp
package regfile_pkg;

    typedef enum logic {IDLE, DUMP} dump_state_t;

    localparam int ZERO_REG = 0;

    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// regfile_dump_fsm: streams every register entry out, one per clock, on request
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int ADDR_W = addr_w(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tr,
    output logic [ADDR_W-1:0] rd_idx,
    input  logic [XLEN-1:0]   rd_data,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [XLEN-1:0]   dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    localparam int CW = ADDR_W + 1;

    dump_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              done_q, done_d;

    assign rd_idx     = cnt_q[ADDR_W-1:0];
    assign dump_valid = valid_q;
    assign dump_idx   = idx_q;
    assign dump_data  = data_q;
    assign dump_busy  = state_q == DUMP;
    assign dump_done  = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        idx_d   = idx_q;
        data_d  = data_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (tr) begin
                state_d = DUMP;
                cnt_d   = '0;
            end
        end else if (cnt_q == CW'(NREGS)) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end else begin
            valid_d = 1'b1;
            idx_d   = cnt_q[ADDR_W-1:0];
            data_d  = rd_data;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-read-port register file with write bypass; dump engine under REGFILE_DUMP_EN
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    localparam int ADDR_W = addr_w(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*ADDR_W-1:0] rs,
    output logic [NREAD*XLEN-1:0]   rsData,
    input  logic [ADDR_W-1:0]       rd,
    input  logic                    writeEnable,
    input  logic [XLEN-1:0]         data,
    input  logic                    tr,
    output logic                    dumpValid,
    output logic [ADDR_W-1:0]       dumpIdx,
    output logic [XLEN-1:0]         dumpData,
    output logic                    dumpBusy,
    output logic                    dumpDone
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wr_ok;

    assign wr_ok = writeEnable && rd != ADDR_W'(ZERO_REG);

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) regs_d[rd] = data;
    end

    always_ff @(posedge clk) begin
        if (rst) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
    end

    // Register 0 is never written, so the array path already reads it as 0.
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rs[k*ADDR_W +: ADDR_W];
        assign rsData[k*XLEN +: XLEN] = (wr_ok && rd == a) ? data : regs_q[a];
    end

`ifdef REGFILE_DUMP_EN
    logic [ADDR_W-1:0] dump_rd_idx;

    regfile_dump_fsm #(.XLEN(XLEN), .NREGS(NREGS)) u_dump (
        .clk        (clk),
        .rst        (rst),
        .tr         (tr),
        .rd_idx     (dump_rd_idx),
        .rd_data    (regs_q[dump_rd_idx]),
        .dump_valid (dumpValid),
        .dump_idx   (dumpIdx),
        .dump_data  (dumpData),
        .dump_busy  (dumpBusy),
        .dump_done  (dumpDone)
    );
`else
    logic unused_tr;
    assign unused_tr = tr;
    assign dumpValid = 1'b0;
    assign dumpIdx   = '0;
    assign dumpData  = '0;
    assign dumpBusy  = 1'b0;
    assign dumpDone  = 1'b0;
`endif

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: randomized self-checking bench against an array reference model
module tb_register_file_mp;

    localparam int XLEN = 32, NREGS = 32, NREAD = 2, AW = 5;

    logic              clk = 1'b0;
    logic              rst, we, tr;
    logic [AW-1:0]     rd;
    logic [XLEN-1:0]   data;
    logic [NREAD*AW-1:0]   rs;
    logic [NREAD*XLEN-1:0] rs_data;
    logic              d_valid, d_busy, d_done;
    logic [AW-1:0]     d_idx;
    logic [XLEN-1:0]   d_data;

    logic [XLEN-1:0] model [NREGS];
    logic [XLEN-1:0] e;
    int checks = 0, errors = 0;

    register_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
        .clk(clk), .rst(rst), .rs(rs), .rsData(rs_data), .rd(rd),
        .writeEnable(we), .data(data), .tr(tr),
        .dumpValid(d_valid), .dumpIdx(d_idx), .dumpData(d_data),
        .dumpBusy(d_busy), .dumpDone(d_done)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        return (a == 0) ? '0 : (we && rd == a) ? data : model[a];
    endfunction

    task automatic step;
        @(posedge clk);
        if (rst) foreach (model[i]) model[i] = '0;
        else if (we && rd != 0) model[rd] = data;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; tr = 1'b0;
        repeat (20) begin we = 1'b1; rd = AW'($urandom); data = $urandom; step; end
        rd = 5'd3; data = 32'hA5A5A5A5; rst = 1'b1;
        step;
        rst = 1'b0; we = 1'b0;
        checks++;
        if ({d_valid, d_idx, d_data, d_busy, d_done} !== '0) begin
            errors++; $display("FAIL reset_dump got %h exp 0", {d_valid, d_idx, d_data, d_busy, d_done});
        end
        for (int a = 0; a < NREGS; a++) begin
            rs = {AW'(a), AW'(a)}; #1;
            checks++;
            if (rs_data !== '0) begin errors++; $display("FAIL reset_read[%0d] got %h exp 0", a, rs_data); end
        end
    endtask

    task automatic test_bypass;
        we = 1'b1; rd = 5'd5; data = 32'hDEADBEEF; rs = {5'd1, 5'd5}; #1;
        checks++;
        if (rs_data[XLEN-1:0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_same got %h exp deadbeef", rs_data[XLEN-1:0]);
        end
        step;
        we = 1'b0; #1;
        checks++;
        if (rs_data[XLEN-1:0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_next got %h exp deadbeef", rs_data[XLEN-1:0]);
        end
    endtask

    task automatic test_zero;
        we = 1'b1; rd = 5'd0; data = 32'h1234; rs = '0; #1;
        checks++;
        if (rs_data !== '0) begin errors++; $display("FAIL zero_bypass got %h exp 0", rs_data); end
        step;
        we = 1'b0; #1;
        checks++;
        if (rs_data !== '0) begin errors++; $display("FAIL zero_reg got %h exp 0", rs_data); end
    endtask

    task automatic test_random;
        repeat (300) begin
            we = 1'($urandom); rd = AW'($urandom); data = $urandom;
            rs[AW-1:0]    = ($urandom_range(2) == 0) ? rd : AW'($urandom);
            rs[2*AW-1:AW] = ($urandom_range(3) == 0) ? rd : AW'($urandom);
            #1;
            for (int k = 0; k < NREAD; k++) begin
                e = exp_rd(rs[k*AW +: AW]);
                checks++;
                if (rs_data[k*XLEN +: XLEN] !== e) begin
                    errors++; $display("FAIL rand_read p%0d a%0d got %h exp %h", k, rs[k*AW +: AW], rs_data[k*XLEN +: XLEN], e);
                end
            end
            step;
        end
        we = 1'b0;
    endtask

`ifdef REGFILE_DUMP_EN
    always @(negedge clk) if (d_valid) $display("R[%0d] = %0d", d_idx, d_data);

    task automatic test_dump;
        for (int i = 1; i < NREGS; i++) begin we = 1'b1; rd = AW'(i); data = i * 3; step; end
        we = 1'b0; tr = 1'b1;
        step;
        tr = 1'b0;
        checks++;
        if (d_busy !== 1'b1 || d_valid !== 1'b0) begin
            errors++; $display("FAIL dump_start busy %b valid %b exp 1 0", d_busy, d_valid);
        end
        for (int j = 1; j <= NREGS; j++) begin
            tr = (j == 5);
            e = model[j-1];
            step;
            checks++;
            if (d_valid !== 1'b1 || d_idx !== AW'(j-1) || d_data !== e || d_done !== 1'b0 || d_busy !== 1'b1) begin
                errors++; $display("FAIL dump_entry j%0d got v%b i%0d d%0d dn%b b%b exp idx %0d data %0d", j, d_valid, d_idx, d_data, d_done, d_busy, j-1, e);
            end
        end
        tr = 1'b0;
        step;
        checks++;
        if (d_valid !== 1'b0 || d_done !== 1'b1 || d_busy !== 1'b0) begin
            errors++; $display("FAIL dump_end got v%b dn%b b%b exp 0 1 0", d_valid, d_done, d_busy);
        end
        step;
        checks++;
        if (d_done !== 1'b0 || d_busy !== 1'b0) begin
            errors++; $display("FAIL dump_idle got dn%b b%b exp 0 0", d_done, d_busy);
        end
    endtask

    task automatic test_back_to_back;
        tr = 1'b1;
        repeat (NREGS + 2) step;
        checks++;
        if (d_done !== 1'b1 || d_busy !== 1'b0) begin
            errors++; $display("FAIL b2b_gap got dn%b b%b exp 1 0", d_done, d_busy);
        end
        step;
        checks++;
        if (d_busy !== 1'b1 || d_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_rearm got b%b v%b exp 1 0", d_busy, d_valid);
        end
        tr = 1'b0;
        e = model[0];
        step;
        checks++;
        if (d_valid !== 1'b1 || d_idx !== '0 || d_data !== e) begin
            errors++; $display("FAIL b2b_first got v%b i%0d d%h exp 1 0 %h", d_valid, d_idx, d_data, e);
        end
        repeat (NREGS + 1) step;
    endtask

    task automatic test_dump_write;
        tr = 1'b1;
        step;
        tr = 1'b0;
        for (int j = 1; j <= NREGS; j++) begin
            e = model[j-1];
            we = (j == 8); rd = 5'd7; data = 32'd99;
            step;
            checks++;
            if (d_idx !== AW'(j-1) || d_data !== e) begin
                errors++; $display("FAIL dwrite_entry j%0d got i%0d d%0d exp i%0d d%0d", j, d_idx, d_data, j-1, e);
            end
        end
        we = 1'b0;
        step; step;
        rs = {5'd0, 5'd7}; #1;
        checks++;
        if (rs_data[XLEN-1:0] !== 32'd99) begin
            errors++; $display("FAIL dwrite_read got %0d exp 99", rs_data[XLEN-1:0]);
        end
    endtask

    task automatic test_dump_reset;
        tr = 1'b1;
        step;
        tr = 1'b0;
        repeat (9) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        checks++;
        if ({d_valid, d_idx, d_data, d_busy, d_done} !== '0) begin
            errors++; $display("FAIL dreset_out got %h exp 0", {d_valid, d_idx, d_data, d_busy, d_done});
        end
        we = 1'b1; rd = 5'd1; data = $urandom;
        step;
        we = 1'b0; tr = 1'b1;
        step;
        tr = 1'b0;
        step;
        checks++;
        if (d_valid !== 1'b1 || d_idx !== '0 || d_data !== '0) begin
            errors++; $display("FAIL drestart_0 got v%b i%0d d%h exp 1 0 0", d_valid, d_idx, d_data);
        end
        e = model[1];
        step;
        checks++;
        if (d_idx !== 5'd1 || d_data !== e) begin
            errors++; $display("FAIL drestart_1 got i%0d d%h exp 1 %h", d_idx, d_data, e);
        end
        repeat (NREGS + 1) step;
        checks++;
        if (d_busy !== 1'b0) begin errors++; $display("FAIL drestart_end got b%b exp 0", d_busy); end
    endtask
`else
    task automatic test_no_dump;
        repeat (60) begin
            tr = 1'($urandom); we = 1'($urandom); rd = AW'($urandom); data = $urandom;
            step;
            checks++;
            if ({d_valid, d_idx, d_data, d_busy, d_done} !== '0) begin
                errors++; $display("FAIL nodump_out got %h exp 0", {d_valid, d_idx, d_data, d_busy, d_done});
            end
        end
        tr = 1'b0; we = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; we = 1'b0; tr = 1'b0; rd = '0; data = '0; rs = '0;
        foreach (model[i]) model[i] = '0;
        step;
        test_reset;
        test_bypass;
        test_zero;
        test_random;
`ifdef REGFILE_DUMP_EN
        test_dump;
        test_back_to_back;
        test_dump_write;
        test_dump_reset;
`else
        test_no_dump;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
